rggen_bit_field_access_driver: RTL and testbench
================================================

// Module: rggen_bit_field_access_driver
// PURPOSE
//   Master-side driver of rggen_bit_field_if. It turns a valid/ready register request
//   (read or write, byte strobes) into one bit-field access cycle, samples read data
//   after a fixed latency, and returns a response on a valid/ready channel.
//   Sits between the host bus decode and the bit-field slaves (rw/ro/... fields).
// PARAMETERS
//   DATA_WIDTH    32  request/response data width; multiple of 8, <= bit_field_if width
//   READ_LATENCY  0   extra cycles after the access cycle before read_data is sampled (0..15)
// PORTS
//   clk           input   1             clock; all logic on posedge
//   rst           input   1             asynchronous reset, active-high
//   i_req_valid   input   1             request valid
//   o_req_ready   output  1             request ready (1 only in IDLE, 0 while rst=1)
//   i_req_write   input   1             1=write, 0=read
//   i_req_data    input   DATA_WIDTH    write data
//   i_req_strobe  input   DATA_WIDTH/8  byte write strobes (ignored on reads)
//   o_rsp_valid   output  1             response valid
//   i_rsp_ready   input   1             response ready
//   o_rsp_data    output  DATA_WIDTH    read data; 0 for write responses
//   bit_field_if  master  -             drives write_access/write_data/write_mask; reads read_data
// BEHAVIOUR
//   - Reset: async, active-high. State=IDLE, o_rsp_valid=0, o_rsp_data=0,
//     write_access=0, write_data=0, write_mask=0, request regs=0, latency counter=0.
//     Asserting rst mid-transaction aborts it immediately; write_access drops asynchronously.
//   - FSM: IDLE -> ACCESS -> WAIT -> RESPONSE -> IDLE.
//     IDLE: o_req_ready=1; on valid&ready (cycle T) capture write/data/strobe -> ACCESS.
//       Inputs changing after T have no effect on the transaction.
//     ACCESS (T+1, exactly one cycle): for writes, write_access=1,
//       write_data=captured data, write_mask[i]=strobe[i/8]; for reads, all three stay 0.
//       Next state is WAIT when READ_LATENCY>0, else RESPONSE.
//     WAIT: count READ_LATENCY cycles (T+2..T+1+READ_LATENCY) -> RESPONSE.
//     Read sample: read_data[DATA_WIDTH-1:0] is registered into o_rsp_data on the clock
//       edge that ends cycle T+1+READ_LATENCY. Writes load 0.
//     RESPONSE: o_rsp_valid=1 from cycle T+2+READ_LATENCY. o_rsp_data is held stable until
//       rsp_valid&rsp_ready, then -> IDLE and o_rsp_valid=0 on the next cycle.
//   - Throughput: at most one transaction per 3+READ_LATENCY cycles with i_rsp_ready held at 1.
//     No pipelining; o_req_ready=0 outside IDLE.
//   - write_data/write_mask are 0 in every cycle except ACCESS of a write.
//     Bits above DATA_WIDTH on the interface are driven to 0.
//   - Write with strobe=0: the access cycle still occurs with write_access=1 and mask=0,
//     so there is no field change; a normal response follows.
//   - Response backpressure: an unbounded i_rsp_ready=0 stall is legal; state holds.
//   - No error signalling; every accepted request produces exactly one response.
// STRUCTURE
//   - rggen_rtl_pkg: function expand_byte_strobe(strobe) -> bit mask (shared with other
//     host bridges). The state enum is local (typedef enum logic [1:0]).
//   - Single module. Latency counter is $clog2(READ_LATENCY+1) bits, omitted when
//     READ_LATENCY=0 (generate). No sub-module needed.
// TESTING
//   1 Write 0xA5A5_5A5A, strobe 4'b1111, L=0 -> write_access=1 only at T+1 with
//     mask=0xFFFF_FFFF; rsp_valid at T+2, rsp_data=0; rw field reads back 0xA5A5_5A5A.
//   2 Write 0x1234_5678, strobe 4'b0101 over field value 0xFFFF_FFFF ->
//     mask=0x00FF_00FF; field becomes 0xFF34_FF78.
//   3 Read, READ_LATENCY=3, field=0xDEAD_BEEF -> read_data sampled at end of T+4;
//     rsp_valid at T+5; rsp_data=0xDEAD_BEEF.
//   4 Hold i_rsp_ready=0 for 10 cycles, toggling i_req_* -> o_req_ready=0 throughout;
//     rsp_data stable; accept after ready; next request accepted the following cycle.
//   5 Assert rst during ACCESS of a write -> write_access=0 in same cycle, rsp_valid=0;
//     after release, o_req_ready=1 and no response is emitted for the aborted request.
//   6 Back-to-back read/write/read with i_rsp_ready=1, L=0 -> accepts every 3 cycles,
//     responses in order, write response data=0.

Source files
------------

// File: rtl/rggen_rtl_pkg.sv
// Shared helpers for host bridges that drive rggen bit-field interfaces.
// Widths are sized for the widest supported bus; callers slice what they need.
package rggen_rtl_pkg;

    localparam int RGGEN_MAX_DATA_WIDTH   = 128;
    localparam int RGGEN_MAX_STROBE_WIDTH = RGGEN_MAX_DATA_WIDTH / 8;

    function automatic logic [RGGEN_MAX_DATA_WIDTH-1:0] expand_byte_strobe(
        input logic [RGGEN_MAX_STROBE_WIDTH-1:0] strobe
    );
        logic [RGGEN_MAX_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < RGGEN_MAX_STROBE_WIDTH; i++) begin
            mask[8*i+:8] = {8{strobe[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/rggen_bit_field_if.sv
// Bit-field access bundle between a host-side driver and the field slaves.
interface rggen_bit_field_if #(
    parameter int WIDTH = 32
);
    logic             write_access;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] write_mask;
    logic [WIDTH-1:0] read_data;

    modport master (
        output write_access,
        output write_data,
        output write_mask,
        input  read_data
    );

    modport slave (
        input  write_access,
        input  write_data,
        input  write_mask,
        output read_data
    );
endinterface

// File: rtl/rggen_bit_field_access_driver.sv
// Turns one valid/ready register request into a single bit-field access cycle
// and returns read data (or zero for writes) on a valid/ready response channel.
module rggen_bit_field_access_driver
    import rggen_rtl_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int READ_LATENCY    = 0,
    parameter int BIT_FIELD_WIDTH = DATA_WIDTH
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_write,
    input  logic [DATA_WIDTH-1:0]   i_req_data,
    input  logic [DATA_WIDTH/8-1:0] i_req_strobe,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_data,
    rggen_bit_field_if.master       bit_field_if
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESPONSE
    } state_e;

    state_e                  state;
    logic                    req_write;
    logic [DATA_WIDTH-1:0]   req_data;
    logic [STRB_W-1:0]       req_strobe;
    logic                    wait_done;
    logic                    write_phase;
    logic [DATA_WIDTH-1:0]   read_slice;
    logic [DATA_WIDTH-1:0]   rsp_sample;

    logic [RGGEN_MAX_STROBE_WIDTH-1:0] strobe_ext;
    logic [RGGEN_MAX_DATA_WIDTH-1:0]   mask_full;
    logic [DATA_WIDTH-1:0]             access_mask;

    // Ready is gated by rst so the host never sees a handshake during reset.
    assign o_req_ready = (state == ST_IDLE) && !rst;

    assign strobe_ext  = RGGEN_MAX_STROBE_WIDTH'(req_strobe);
    assign mask_full   = expand_byte_strobe(strobe_ext);
    assign access_mask = mask_full[DATA_WIDTH-1:0];

    // Access outputs decode straight from state so an async reset drops them at once.
    assign write_phase               = (state == ST_ACCESS) && req_write;
    assign bit_field_if.write_access = write_phase;
    assign bit_field_if.write_data   = write_phase ? BIT_FIELD_WIDTH'(req_data)    : '0;
    assign bit_field_if.write_mask   = write_phase ? BIT_FIELD_WIDTH'(access_mask) : '0;

    assign read_slice = bit_field_if.read_data[DATA_WIDTH-1:0];
    assign rsp_sample = req_write ? '0 : read_slice;

    if (DATA_WIDTH < RGGEN_MAX_DATA_WIDTH) begin : g_mask_hi
        logic unused_mask_hi;
        assign unused_mask_hi = ^mask_full[RGGEN_MAX_DATA_WIDTH-1:DATA_WIDTH];
    end

    if (BIT_FIELD_WIDTH > DATA_WIDTH) begin : g_read_hi
        logic unused_read_hi;
        assign unused_read_hi = ^bit_field_if.read_data[BIT_FIELD_WIDTH-1:DATA_WIDTH];
    end

    if (READ_LATENCY > 0) begin : g_wait
        logic [CNT_W-1:0] wait_cnt;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end

        assign wait_done = (wait_cnt == CNT_W'(READ_LATENCY - 1));
    end else begin : g_no_wait
        assign wait_done = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_write   <= 1'b0;
            req_data    <= '0;
            req_strobe  <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req_write  <= i_req_write;
                        req_data   <= i_req_data;
                        req_strobe <= i_req_strobe;
                        state      <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (READ_LATENCY == 0) begin
                        o_rsp_data  <= rsp_sample;
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESPONSE;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_done) begin
                        o_rsp_data  <= rsp_sample;
                        o_rsp_valid <= 1'b1;
                        state       <= ST_RESPONSE;
                    end
                end
                ST_RESPONSE: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rggen_bit_field_access_driver.sv
// Bench: two drivers (read latency 0 and 3), each with an rw field model,
// checked by a vector table plus a response scoreboard.
module tb_rggen_bit_field_access_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       req_valid, req_write, req_ready, rsp_valid, rsp_ready;
    logic [1:0][31:0] req_data, rsp_data;
    logic [1:0][3:0]  req_strobe;
    logic [1:0]       wa;
    logic [1:0][31:0] wd, wm;
    logic [1:0][31:0] field = '0;

    rggen_bit_field_if #(.WIDTH(32)) bf0 ();
    rggen_bit_field_if #(.WIDTH(32)) bf1 ();

    rggen_bit_field_access_driver #(.DATA_WIDTH(32), .READ_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
        .i_req_write(req_write[0]), .i_req_data(req_data[0]), .i_req_strobe(req_strobe[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_data(rsp_data[0]),
        .bit_field_if(bf0)
    );

    rggen_bit_field_access_driver #(.DATA_WIDTH(32), .READ_LATENCY(3)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
        .i_req_write(req_write[1]), .i_req_data(req_data[1]), .i_req_strobe(req_strobe[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_data(rsp_data[1]),
        .bit_field_if(bf1)
    );

    assign wa[0] = bf0.write_access;  assign wa[1] = bf1.write_access;
    assign wd[0] = bf0.write_data;    assign wd[1] = bf1.write_data;
    assign wm[0] = bf0.write_mask;    assign wm[1] = bf1.write_mask;
    assign bf0.read_data = field[0];
    assign bf1.read_data = field[1];

    // rw field slaves
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (wa[d]) field[d] <= (field[d] & ~wm[d]) | (wd[d] & wm[d]);
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    time last_acc[2];

    function automatic int lat(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard pop: any completed response handshake
    logic [31:0] mon_exp;
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsp_valid[d] && rsp_ready[d]) begin
                if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected dut%0d: got data %h, required no response", d, rsp_data[d]);
                end else begin
                    mon_exp = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("rsp_data_dut%0d", d), rsp_data[d], mon_exp);
                end
            end
        end
    end

    task automatic do_xact(input int d, input bit wr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [31:0] exp_mask,
                           input logic [31:0] exp_rsp, input int stall, input bit chk_gap);
        int k;
        @(negedge clk);
        if (stall > 0) rsp_ready[d] = 1'b0;
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1; req_write[d] = wr; req_data[d] = data; req_strobe[d] = strb;
        @(posedge clk);
        if (chk_gap) chk("accept_gap", 32'(($time - last_acc[d]) / 10), 32'(3 + lat(d)));
        last_acc[d] = $time;
        if (d == 0) q0.push_back(wr ? 32'd0 : exp_rsp);
        else        q1.push_back(wr ? 32'd0 : exp_rsp);
        @(negedge clk);
        chk("wr_access_t1", 32'(wa[d]), 32'(wr));
        chk("wr_mask_t1",   wm[d], wr ? exp_mask : 32'd0);
        chk("wr_data_t1",   wd[d], wr ? data : 32'd0);
        chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
        req_valid[d] = 1'b0; req_write[d] = 1'($urandom);
        req_data[d] = $urandom; req_strobe[d] = 4'($urandom);
        @(negedge clk);
        chk("wr_access_t2", 32'(wa[d]), 32'd0);
        chk("wr_mask_t2",   wm[d], 32'd0);
        chk("wr_data_t2",   wd[d], 32'd0);
        k = 2;
        while (!rsp_valid[d] && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_latency", 32'(k), 32'(2 + lat(d)));
        for (int s = 0; s < stall; s++) begin
            chk("stall_rsp_valid", 32'(rsp_valid[d]), 32'd1);
            chk("stall_rsp_data",  rsp_data[d], wr ? 32'd0 : exp_rsp);
            chk("stall_req_ready", 32'(req_ready[d]), 32'd0);
            req_valid[d] = 1'($urandom); req_write[d] = 1'($urandom);
            req_data[d] = $urandom; req_strobe[d] = 4'($urandom);
            @(negedge clk);
        end
        if (stall > 0) begin
            req_valid[d] = 1'b0;
            @(posedge clk);
            #1 rsp_ready[d] = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_mask;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{0, 1'b1, 32'hA5A5_5A5A, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hA5A5_5A5A};
        vecs[2]  = '{0, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[3]  = '{0, 1'b1, 32'h1234_5678, 4'b0101, 32'h00FF_00FF, 32'h0};
        vecs[4]  = '{0, 1'b0, 32'h0,         4'b1111, 32'h0,         32'hFF34_FF78};
        vecs[5]  = '{0, 1'b1, 32'h0000_0000, 4'b0000, 32'h0,         32'h0};
        vecs[6]  = '{0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hFF34_FF78};
        vecs[7]  = '{0, 1'b1, 32'h0000_00AA, 4'b0001, 32'h0000_00FF, 32'h0};
        vecs[8]  = '{0, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hFF34_FFAA};
        vecs[9]  = '{1, 1'b1, 32'hDEAD_BEEF, 4'b1111, 32'hFFFF_FFFF, 32'h0};
        vecs[10] = '{1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hDEAD_BEEF};
        vecs[11] = '{1, 1'b1, 32'h0000_CAFE, 4'b0011, 32'h0000_FFFF, 32'h0};
        vecs[12] = '{1, 1'b0, 32'h0,         4'b0000, 32'h0,         32'hDEAD_CAFE};

        req_valid = '0; req_write = '0; req_data = '0; req_strobe = '0; rsp_ready = 2'b11;
        last_acc[0] = 0; last_acc[1] = 0;

        // Reset state
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rsp_data",  rsp_data[d], 32'd0);
            chk("rst_wr_access", 32'(wa[d]), 32'd0);
            chk("rst_wr_mask",   wm[d], 32'd0);
            chk("rst_wr_data",   wd[d], 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 13; i++) begin
            do_xact(vecs[i].d, vecs[i].wr, vecs[i].data, vecs[i].strb,
                    vecs[i].exp_mask, vecs[i].exp_rsp, 0,
                    (i > 0) && (vecs[i-1].d == vecs[i].d));
        end

        // Response backpressure, then an immediate follow-on request
        do_xact(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFF34_FFAA, 10, 1'b0);
        do_xact(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFF34_FFAA, 0, 1'b0);

        // Reset during the access cycle of a write aborts it
        @(negedge clk);
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_data[0] = 32'h5555_5555; req_strobe[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("abort_wr_access_pre", 32'(wa[0]), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_wr_access", 32'(wa[0]), 32'd0);
        chk("abort_wr_mask",   wm[0], 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("abort_req_ready", 32'(req_ready[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
            chk("post_abort_req_ready", 32'(req_ready[0]), 32'd1);
        end
        do_xact(0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFF34_FFAA, 0, 1'b0);
        do_xact(1, 1'b0, 32'h0, 4'h0, 32'h0, 32'hDEAD_CAFE, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drain_dut0", 32'(q0.size()), 32'd0);
        chk("sb_drain_dut1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
